// File: rtl/if_id_skid_buffer.sv
// IF/ID two-entry elastic buffer: main register feeds decode, skid register absorbs one stalled fetch.
// Latency 1 cycle from accept to id_valid; if_ready comes from registered state only, so it drops
// the cycle after decode stalls with an entry in flight. Optional counters under IFID_PERF_CNT_EN.
module if_id_skid_buffer #(
    parameter logic [31:0] NOP = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc_plus4,
    output logic        if_ready,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc_plus4,
    input  logic        id_ready,
    input  logic        flush
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] main_instr_q, main_instr_d;
    logic [31:0] main_pc_q, main_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        accept;
    logic        consume;

    assign if_ready       = (state_q != TWO);
    assign id_valid       = (state_q != EMPTY);
    assign id_instruction = main_instr_q;
    assign id_pc_plus4    = main_pc_q;

    assign accept  = if_valid & if_ready;
    assign consume = id_valid & id_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            // Skid contents are simply abandoned; state marks them invalid.
            state_d      = EMPTY;
            main_instr_d = NOP;
            main_pc_d    = 32'h0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        main_instr_d = if_instruction;
                        main_pc_d    = if_pc_plus4;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_instr_d = if_instruction;
                        main_pc_d    = if_pc_plus4;
                    end else if (accept) begin
                        state_d      = TWO;
                        skid_instr_d = if_instruction;
                        skid_pc_d    = if_pc_plus4;
                    end else if (consume) begin
                        state_d      = EMPTY;
                        main_instr_d = NOP;
                        main_pc_d    = 32'h0;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state_d      = ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    main_instr_d = NOP;
                    main_pc_d    = 32'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            main_instr_q <= NOP;
            main_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'h0;
            flush_count_q  <= 16'h0;
        end else begin
            if (if_valid && !if_ready) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            // Flush count saturates; stall count wraps.
            if (flush && (flush_count_q != 16'hFFFF)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end
`endif

endmodule
